mul_arbiter: RTL
================

# mul_arbiter

Round-robin scheduler that shares one sequential 8x8 signed Booth multiplier between two requesters. It accepts an operand pair from the winning requester and pulses the multiplier's start. It then tracks the multiplier's busy flag, captures the 16-bit product on the single cycle it is valid, and returns it with a done pulse to the owner. It sits between the multiplier and the two datapath clients that need multiply service.

## Interface
- TMO_CYCLES, 12: maximum number of RUN cycles before a timeout abort. Used only with the timeout macro.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0 / req1  in  1  request; held high with operands stable until the matching gnt.
- mc0, mp0 / mc1, mp1  in  8  multiplicand and multiplier, signed two's complement.
- gnt0 / gnt1  out  1  one-cycle pulse; operands are sampled on this cycle.
- done0 / done1  out  1  one-cycle pulse; res (and err) are valid on this cycle.
- res  out  16  signed product, shared by both requesters and held between operations.
- err  out  1  timeout flag, qualified by doneN; constant 0 when the timeout macro is absent.
- mul_start  out  1  start strobe to the multiplier.
- mul_mc, mul_mp  out  8  registered operands to the multiplier.
- mul_busy  in  1  multiplier busy flag.
- mul_prod  in  16  multiplier product, {A,Q}.

## Operation
- States are IDLE, START, RUN and DONE. The owner register (own) records which requester is being served.
- **IDLE**
  - Arbitrate among the asserted reqN.
  - If only one request is asserted, it wins.
  - If both are asserted, the requester selected by the priority pointer prio wins. prio resets to 0.
  - The winner gets a gnt pulse in this same cycle.
  - At the clock edge, the winner's operands are latched into mul_mc/mul_mp, own is set to the winner, prio is set to the non-winner, and the state moves to START.
- **START**
  - mul_start=1 for exactly this cycle, then go to RUN.
- **RUN**
  - mul_start=0.
  - On the first RUN cycle with mul_busy=0, sample mul_prod into res and go to DONE.
  - mul_prod is valid only in that cycle: the multiplier keeps shifting and its 4-bit counter wraps, so late sampling is wrong.
- **DONE**
  - done[own]=1 for one cycle, then return to IDLE.
  - A new grant is not possible in DONE; the earliest next grant is the following cycle.
- gntN and doneN are never asserted for both requesters in the same cycle.
- res holds its value until the next capture.
- mul_mc and mul_mp hold their values outside IDLE acceptance.
- A reqN that drops before its grant is simply not served; there is no error.
- **Reset**
  - Applies in any state, including mid-RUN.
  - Next state is IDLE; prio=0; res=0.
  - gnt0, gnt1, done0, done1, err and mul_start are all 0; mul_mc=mul_mp=0.
  - Any in-flight result is discarded and no done pulse is issued.
  - The multiplier is left running and is ignored.

## Timing
- Request accepted (gnt) in cycle T:
  - T+1: START, mul_start=1.
  - T+2 to T+9: RUN with mul_busy=1 (multiplier counter 0 to 7).
  - T+10: RUN with mul_busy=0; capture.
  - T+11: done, res valid.
- Request-to-done latency is 11 cycles. With requests continuously pending, the grant-to-grant period is 12 cycles.
- Maximum back-to-back grant rate is one every 12 cycles.
- Reset values of all outputs: 0.

## Configuration
- **MUL_ARB_TIMEOUT_EN defined**
  - A RUN cycle counter is active.
  - If mul_busy is still 1 after TMO_CYCLES RUN cycles, the state moves to DONE with res=16'h0000 and err=1 on the done cycle.
  - prio is updated as usual.
- **MUL_ARB_TIMEOUT_EN undefined**
  - No counter; RUN waits indefinitely for mul_busy=0.
  - err is tied to 0.

## Test plan
- **Single request:** after reset, req0 with mc0=8'h03, mp0=8'h05, granted at T. Expect mul_start at T+1, done0 at T+11, res=16'h000F, err=0.
- **Signed operands:** req1 with mc1=8'hF9 (-7), mp1=8'h06. Expect res=16'hFFD6 with done1. Also mc1=8'h7F, mp1=8'hFF; expect res=16'hFF81.
- **Simultaneous requests after reset:** req0 and req1 asserted together. Expect gnt0 at T, done0 at T+11, gnt1 at T+12, done1 at T+23.
- **Both requests held continuously:** expect grants to alternate 0,1,0,1 and never the same requester twice in a row.
- **Reset mid-operation:** rst pulsed at T+5. Expect no done pulse, all outputs 0 on the following cycle, and a fresh req0 handled normally with 11-cycle latency.
- **Stuck busy (MUL_ARB_TIMEOUT_EN, TMO_CYCLES=12):** mul_busy forced to 1. Expect done0 at T+15 with err=1 and res=16'h0000. Without the macro, expect no done pulse.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter
// Round-robin scheduler sharing one sequential 8x8 signed Booth multiplier
// between two requesters. The winner gets a one-cycle gnt pulse while its
// operands are latched, the multiplier is started, its single valid product
// cycle is captured into res, and the owner receives a one-cycle done pulse.
//
// Optional feature: define MUL_ARB_TIMEOUT_EN to abort an operation whose
// multiplier stays busy longer than TMO_CYCLES RUN cycles (res=0, err=1).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req0/req1           requests, held with operands stable until granted
//   mc0,mp0 / mc1,mp1   signed 8-bit multiplicand / multiplier per requester
//   gnt0/gnt1           one-cycle grant pulse, operands sampled this cycle
//   done0/done1         one-cycle completion pulse, res/err valid this cycle
//   res                 signed 16-bit product, held until the next capture
//   err                 timeout flag qualified by doneN (0 without the macro)
//   mul_start           start strobe to the multiplier
//   mul_mc, mul_mp      registered operands to the multiplier
//   mul_busy            multiplier busy flag
//   mul_prod            multiplier product {A,Q}
module mul_arbiter #(
  parameter int TMO_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  mc0,
  input  logic [7:0]  mp0,
  input  logic [7:0]  mc1,
  input  logic [7:0]  mp1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        err,
  output logic        mul_start,
  output logic [7:0]  mul_mc,
  output logic [7:0]  mul_mp,
  input  logic        mul_busy,
  input  logic [15:0] mul_prod
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic   own;
  logic   prio;
  logic   any_req;
  logic   win;
  logic   capture;
  logic   timeout;

  // With a single request it wins outright; prio only breaks a tie.
  assign any_req = req0 | req1;
  assign win     = (req0 & req1) ? prio : req1;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);

  logic [CW-1:0] run_cnt;
  logic          tmo_flag;

  // The counter holds the number of RUN cycles already spent waiting, so the
  // abort fires on the RUN cycle after TMO_CYCLES busy cycles have elapsed.
  assign timeout = (state == RUN) && mul_busy && (run_cnt == CW'(TMO_CYCLES));

  // RUN-cycle counter and sticky timeout flag, cleared at every START.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if (state == START) begin
      run_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if (state == RUN && mul_busy) begin
      if (timeout) begin
        tmo_flag <= 1'b1;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign err = (state == DONE) && tmo_flag && !rst;
`else
  logic unused_tmo;

  assign timeout    = 1'b0;
  assign err        = 1'b0;
  assign unused_tmo = ^TMO_CYCLES;
`endif

  // Next-state and pulse outputs. Every pulse is suppressed while rst is high
  // so an in-flight result is dropped without a done pulse.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mul_start = 1'b0;
    capture   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt0      = !win;
            gnt1      = win;
            state_nxt = START;
          end
        end
        START: begin
          mul_start = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          // The product is valid only on the first non-busy cycle; the
          // multiplier keeps shifting afterwards.
          if (!mul_busy) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else if (timeout) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          done0     = !own;
          done1     = own;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, ownership, round-robin pointer, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      own    <= 1'b0;
      prio   <= 1'b0;
      res    <= '0;
      mul_mc <= '0;
      mul_mp <= '0;
    end else begin
      state <= state_nxt;
      if (gnt0 | gnt1) begin
        own    <= win;
        prio   <= !win;
        mul_mc <= win ? mc1 : mc0;
        mul_mp <= win ? mp1 : mp0;
      end
      if (capture) begin
        res <= mul_prod;
      end else if (timeout) begin
        res <= '0;
      end
    end
  end

endmodule
